// File: rtl/fp_accum_driver.sv
// Accumulating initiator for a stb/ack single-precision float adder: feeds running sum
// plus each incoming term to the adder and emits the group total.
module fp_accum_driver #(
    parameter int unsigned MAX_TERMS = 16,
    parameter int unsigned CNT_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    input  logic             in_stb,
    output logic             in_ack,
    output logic [31:0]      adder_a,
    output logic             adder_a_stb,
    input  logic             adder_a_ack,
    output logic [31:0]      adder_b,
    output logic             adder_b_stb,
    input  logic             adder_b_ack,
    input  logic [31:0]      adder_z,
    input  logic             adder_z_stb,
    output logic             adder_z_ack,
    output logic             adder_idle,
    output logic [31:0]      sum_out,
    output logic [CNT_W-1:0] sum_cnt,
    output logic             sum_stb,
    input  logic             sum_ack
);

    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GET_IN  = 3'd1,
        S_SEND_A  = 3'd2,
        S_SEND_B  = 3'd3,
        S_WAIT_Z  = 3'd4,
        S_PUT_SUM = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_term;
    logic              r_last;
    logic [CNT_W-1:0]  r_cnt;

    logic              r_in_ack;
    logic [DATA_W-1:0] r_adder_a;
    logic              r_adder_a_stb;
    logic [DATA_W-1:0] r_adder_b;
    logic              r_adder_b_stb;
    logic              r_adder_z_ack;
    logic              r_adder_idle;
    logic [DATA_W-1:0] r_sum_out;
    logic [CNT_W-1:0]  r_sum_cnt;
    logic              r_sum_stb;

    logic [DATA_W-1:0] w_acc_nxt;
    logic [DATA_W-1:0] w_term_nxt;
    logic              w_last_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_in_ack_nxt;
    logic [DATA_W-1:0] w_adder_a_nxt;
    logic              w_adder_a_stb_nxt;
    logic [DATA_W-1:0] w_adder_b_nxt;
    logic              w_adder_b_stb_nxt;
    logic              w_adder_z_ack_nxt;
    logic              w_adder_idle_nxt;
    logic [DATA_W-1:0] w_sum_out_nxt;
    logic [CNT_W-1:0]  w_sum_cnt_nxt;
    logic              w_sum_stb_nxt;

    logic              w_in_xfer;
    logic              w_a_xfer;
    logic              w_b_xfer;
    logic              w_z_xfer;
    logic              w_sum_xfer;
    logic              w_group_done;

    // Handshakes; z is gated by state so the adder's post-handshake z_stb pulse is dropped.
    assign w_in_xfer    = in_stb && r_in_ack;
    assign w_a_xfer     = r_adder_a_stb && adder_a_ack;
    assign w_b_xfer     = r_adder_b_stb && adder_b_ack;
    assign w_z_xfer     = adder_z_stb && r_adder_z_ack && (r_state == S_WAIT_Z);
    assign w_sum_xfer   = r_sum_stb && sum_ack;
    assign w_group_done = r_last || (r_cnt == CNT_W'(MAX_TERMS));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_state_nxt = S_GET_IN;
                end
            end
            S_GET_IN: begin
                if (w_in_xfer) begin
                    w_state_nxt = S_SEND_A;
                end else if (!en && (r_cnt == '0)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SEND_A: begin
                if (w_a_xfer) begin
                    w_state_nxt = S_SEND_B;
                end
            end
            S_SEND_B: begin
                if (w_b_xfer) begin
                    w_state_nxt = S_WAIT_Z;
                end
            end
            S_WAIT_Z: begin
                if (w_z_xfer) begin
                    w_state_nxt = w_group_done ? S_PUT_SUM : S_GET_IN;
                end
            end
            S_PUT_SUM: begin
                if (w_sum_xfer) begin
                    w_state_nxt = en ? S_GET_IN : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output/datapath next values; strobes follow the state being entered so they are registered.
    always_comb begin
        w_acc_nxt  = r_acc;
        w_term_nxt = r_term;
        w_last_nxt = r_last;
        w_cnt_nxt  = r_cnt;

        if (w_in_xfer) begin
            w_term_nxt = in_data;
            w_last_nxt = in_last;
            w_cnt_nxt  = r_cnt + CNT_W'(1);
        end
        if (w_z_xfer) begin
            w_acc_nxt = adder_z;
        end
        if (w_sum_xfer) begin
            w_acc_nxt = '0;
            w_cnt_nxt = '0;
        end

        w_in_ack_nxt      = (w_state_nxt == S_GET_IN);
        w_adder_a_stb_nxt = (w_state_nxt == S_SEND_A);
        w_adder_b_stb_nxt = (w_state_nxt == S_SEND_B);
        w_adder_z_ack_nxt = (w_state_nxt == S_WAIT_Z);
        w_sum_stb_nxt     = (w_state_nxt == S_PUT_SUM);
        w_adder_idle_nxt  = (w_state_nxt == S_IDLE);

        w_adder_a_nxt = (w_state_nxt == S_SEND_A)  ? r_acc     : r_adder_a;
        w_adder_b_nxt = (w_state_nxt == S_SEND_B)  ? r_term    : r_adder_b;
        w_sum_out_nxt = (w_state_nxt == S_PUT_SUM) ? w_acc_nxt : r_sum_out;
        w_sum_cnt_nxt = (w_state_nxt == S_PUT_SUM) ? w_cnt_nxt : r_sum_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc         <= '0;
            r_term        <= '0;
            r_last        <= 1'b0;
            r_cnt         <= '0;
            r_in_ack      <= 1'b0;
            r_adder_a     <= '0;
            r_adder_a_stb <= 1'b0;
            r_adder_b     <= '0;
            r_adder_b_stb <= 1'b0;
            r_adder_z_ack <= 1'b0;
            r_adder_idle  <= 1'b1;
            r_sum_out     <= '0;
            r_sum_cnt     <= '0;
            r_sum_stb     <= 1'b0;
        end else begin
            r_acc         <= w_acc_nxt;
            r_term        <= w_term_nxt;
            r_last        <= w_last_nxt;
            r_cnt         <= w_cnt_nxt;
            r_in_ack      <= w_in_ack_nxt;
            r_adder_a     <= w_adder_a_nxt;
            r_adder_a_stb <= w_adder_a_stb_nxt;
            r_adder_b     <= w_adder_b_nxt;
            r_adder_b_stb <= w_adder_b_stb_nxt;
            r_adder_z_ack <= w_adder_z_ack_nxt;
            r_adder_idle  <= w_adder_idle_nxt;
            r_sum_out     <= w_sum_out_nxt;
            r_sum_cnt     <= w_sum_cnt_nxt;
            r_sum_stb     <= w_sum_stb_nxt;
        end
    end

    assign in_ack      = r_in_ack;
    assign adder_a     = r_adder_a;
    assign adder_a_stb = r_adder_a_stb;
    assign adder_b     = r_adder_b;
    assign adder_b_stb = r_adder_b_stb;
    assign adder_z_ack = r_adder_z_ack;
    assign adder_idle  = r_adder_idle;
    assign sum_out     = r_sum_out;
    assign sum_cnt     = r_sum_cnt;
    assign sum_stb     = r_sum_stb;

endmodule

// File: tb/tb_fp_accum_driver.sv
// Bench for fp_accum_driver: directed groups, a table-driven adder model and a sum scoreboard.
module tb_fp_accum_driver;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_stb;
    logic        in_ack;
    logic [31:0] adder_a;
    logic        adder_a_stb;
    logic        adder_a_ack;
    logic [31:0] adder_b;
    logic        adder_b_stb;
    logic        adder_b_ack;
    logic [31:0] adder_z;
    logic        adder_z_stb;
    logic        adder_z_ack;
    logic        adder_idle;
    logic [31:0] sum_out;
    logic [4:0]  sum_cnt;
    logic        sum_stb;
    logic        sum_ack;

    fp_accum_driver #(.MAX_TERMS(4), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .en(en),
        .in_data(in_data), .in_last(in_last), .in_stb(in_stb), .in_ack(in_ack),
        .adder_a(adder_a), .adder_a_stb(adder_a_stb), .adder_a_ack(adder_a_ack),
        .adder_b(adder_b), .adder_b_stb(adder_b_stb), .adder_b_ack(adder_b_ack),
        .adder_z(adder_z), .adder_z_stb(adder_z_stb), .adder_z_ack(adder_z_ack),
        .adder_idle(adder_idle),
        .sum_out(sum_out), .sum_cnt(sum_cnt), .sum_stb(sum_stb), .sum_ack(sum_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        logic [31:0] s;
        logic [4:0]  c;
    } exp_t;
    exp_t sb_q[$];

    task automatic push_exp(input logic [31:0] s, input logic [4:0] c);
        exp_t e;
        e.s = s;
        e.c = c;
        sb_q.push_back(e);
    endtask

    // Hand-computed float sums for the operand pairs the directed groups produce.
    function automatic logic [31:0] add_lut(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] key;
        if (a == 32'h0) return b;
        key = {a, b};
        case (key)
            {32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000;
            {32'h4040_0000, 32'h4040_0000}: return 32'h40C0_0000;
            {32'h3F80_0000, 32'h3F80_0000}: return 32'h4000_0000;
            {32'h4000_0000, 32'h3F80_0000}: return 32'h4040_0000;
            {32'h4040_0000, 32'h3F80_0000}: return 32'h4080_0000;
            {32'h3F80_0000, 32'hBF80_0000}: return 32'h0000_0000;
            default:                        return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Adder model: 0 wait a, 1 wait b, 2 latency, 3 present z, 4 stray z_stb pulse.
    bit          force_z = 1'b0;
    bit          stall_z = 1'b0;
    int          phase;
    int          lat;
    logic [31:0] m_a, m_b, cap_a, cap_b;
    bit          ta, tbx, tz, rs;

    initial begin
        adder_a_ack = 1'b0;
        adder_b_ack = 1'b0;
        adder_z_stb = 1'b0;
        adder_z     = 32'h0;
        phase       = 0;
        lat         = 0;
        m_a         = 32'h0;
        m_b         = 32'h0;
        forever begin
            @(negedge clk);
            rs    = rst;
            ta    = adder_a_stb && adder_a_ack;
            tbx   = adder_b_stb && adder_b_ack;
            tz    = adder_z_stb && adder_z_ack;
            cap_a = adder_a;
            cap_b = adder_b;
            if (!rs && adder_z_stb && phase != 3)
                chk("z_stb_ignored", 32'(adder_z_ack), 32'h0);
            @(posedge clk);
            #1;
            if (rs) begin
                phase = 0;
            end else begin
                case (phase)
                    0: if (ta) begin m_a = cap_a; phase = 1; end
                    1: if (tbx) begin m_b = cap_b; phase = 2; lat = 2; end
                    2: if (!stall_z) begin lat--; if (lat == 0) phase = 3; end
                    3: if (tz) phase = 4;
                    default: phase = 0;
                endcase
            end
            adder_a_ack = (phase == 0);
            adder_b_ack = (phase == 1);
            adder_z_stb = (phase == 3) || (phase == 4) || (phase == 0 && force_z);
            if (phase == 3) begin
                adder_z = add_lut(m_a, m_b);
                if (adder_z == 32'hDEAD_BEEF) chk("adder_operands_known", m_a, 32'h0);
            end else begin
                adder_z = 32'h7F7F_7F7F;
            end
        end
    end

    // Scoreboard monitor for group totals.
    always @(negedge clk) begin
        if (!rst && sum_stb && sum_ack) begin
            if (sb_q.size() == 0) begin
                chk("sum_unexpected", sum_out, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sum_out", sum_out, e.s);
                chk("sum_cnt", 32'(sum_cnt), 32'(e.c));
            end
        end
    end

    task automatic send_term(input logic [31:0] d, input logic l);
        int n;
        in_data = d;
        in_last = l;
        in_stb  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ack && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ack) chk("in_ack_timeout", 32'h0, 32'h1);
        @(posedge clk);
        #1;
        in_stb = 1'b0;
    endtask

    task automatic wait_drained(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(sb_q.size()), 32'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic summary();
        $display("%0d/%0d checks passed", n_pass, n_checks);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_checks++;
        summary();
        $finish;
    end

    initial begin
        int n;
        rst     = 1'b1;
        en      = 1'b0;
        in_data = 32'h0;
        in_last = 1'b0;
        in_stb  = 1'b0;
        sum_ack = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_adder_idle", 32'(adder_idle), 32'h1);
        chk("rst_in_ack", 32'(in_ack), 32'h0);
        chk("rst_a_stb", 32'(adder_a_stb), 32'h0);
        chk("rst_b_stb", 32'(adder_b_stb), 32'h0);
        chk("rst_z_ack", 32'(adder_z_ack), 32'h0);
        chk("rst_sum_stb", 32'(sum_stb), 32'h0);
        chk("rst_sum_out", sum_out, 32'h0);
        chk("rst_sum_cnt", 32'(sum_cnt), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_while_en0", 32'(adder_idle), 32'h1);
        @(posedge clk);
        #1;
        en = 1'b1;

        // 1 + 2 + 3 = 6
        push_exp(32'h40C0_0000, 5'd3);
        send_term(32'h3F80_0000, 1'b0);
        send_term(32'h4000_0000, 1'b0);
        send_term(32'h4040_0000, 1'b1);

        // Group closes at MAX_TERMS=4 without in_last, next group restarts from zero
        push_exp(32'h4080_0000, 5'd4);
        for (int i = 0; i < 4; i++) send_term(32'h3F80_0000, 1'b0);
        push_exp(32'h0000_0000, 5'd2);
        send_term(32'h3F80_0000, 1'b0);
        send_term(32'hBF80_0000, 1'b1);
        wait_drained("drain_groups");

        // Total held under consumer backpressure
        sum_ack = 1'b0;
        push_exp(32'h3F00_0000, 5'd1);
        send_term(32'h3F00_0000, 1'b1);
        n = 0;
        @(negedge clk);
        while (!sum_stb && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("sum_stb_seen", 32'(sum_stb), 32'h1);
        for (int i = 0; i < 10; i++) begin
            chk("hold_sum_stb", 32'(sum_stb), 32'h1);
            chk("hold_sum_out", sum_out, 32'h3F00_0000);
            chk("hold_in_ack", 32'(in_ack), 32'h0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        sum_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("sum_single_xfer", 32'(sum_stb), 32'h0);
        wait_drained("drain_hold");

        // Stray adder_z_stb outside WAIT_Z must not be captured
        force_z = 1'b1;
        push_exp(32'h4000_0000, 5'd1);
        send_term(32'h4000_0000, 1'b1);
        wait_drained("drain_force");
        force_z = 1'b0;

        // Reset while waiting on the adder result
        stall_z = 1'b1;
        send_term(32'h4040_0000, 1'b1);
        n = 0;
        @(negedge clk);
        while (!adder_z_ack && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("reach_wait_z", 32'(adder_z_ack), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_adder_idle", 32'(adder_idle), 32'h1);
        chk("mid_rst_z_ack", 32'(adder_z_ack), 32'h0);
        chk("mid_rst_a_stb", 32'(adder_a_stb), 32'h0);
        chk("mid_rst_b_stb", 32'(adder_b_stb), 32'h0);
        chk("mid_rst_in_ack", 32'(in_ack), 32'h0);
        chk("mid_rst_sum_stb", 32'(sum_stb), 32'h0);
        chk("mid_rst_sum_out", sum_out, 32'h0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        stall_z = 1'b0;
        push_exp(32'h4000_0000, 5'd1);
        send_term(32'h4000_0000, 1'b1);
        wait_drained("drain_after_rst");

        // Park between groups
        en = 1'b0;
        repeat (4) @(negedge clk);
        chk("park_adder_idle", 32'(adder_idle), 32'h1);
        chk("park_in_ack", 32'(in_ack), 32'h0);

        summary();
        $finish;
    end

endmodule
